peripheral_gpio_apb4: RTL and testbench
=======================================

// Module: peripheral_gpio_apb4
// PURPOSE
// - APB4 slave GPIO controller; consumes APB transfers from the AHB3->APB4 bridge on the PCLK side.
// - Provides per-pin direction, push-pull/open-drain mode, output data and synchronized input readback.
// - Provides per-pin level/edge interrupt detection with W1C status and a single combined IRQ.
// PARAMETERS
// - PADDR_SIZE  10  APB address width
// - PDATA_SIZE   8  APB data width = number of GPIO pins
// - SYNC_DEPTH   2  input synchronizer stages; values below 2 are treated as 2
// PORTS
// - PRESETn   in   1           asynchronous active-low reset
// - PCLK      in   1           single clock, all logic on rising edge
// - PSEL      in   1           APB select
// - PENABLE   in   1           APB access phase
// - PADDR     in   PADDR_SIZE  byte address
// - PWRITE    in   1           1 = write
// - PSTRB     in   PDATA_SIZE/8  write byte strobe
// - PWDATA    in   PDATA_SIZE  write data
// - PRDATA    out  PDATA_SIZE  read data
// - PREADY    out  1           always 1; zero wait states
// - PSLVERR   out  1           error response
// - gpio_i    in   PDATA_SIZE  pad inputs, asynchronous
// - gpio_o    out  PDATA_SIZE  pad output values
// - gpio_oe   out  PDATA_SIZE  pad output enables, 1 = drive
// - irq_o     out  1           registered interrupt request
// BEHAVIOUR
// - Register map, decoded on PADDR[2:0]; PADDR[PADDR_SIZE-1:3] != 0 is unmapped:
//   - 0 MODE:   RW; 0 = push-pull, 1 = open-drain
//   - 1 DIR:    RW; 1 = output
//   - 2 OUT:    RW
//   - 3 IN:     RO; synchronized pin value
//   - 4 TTYPE:  RW; 0 = level, 1 = edge
//   - 5 TPOL:   RW; 0 = low/falling, 1 = high/rising
//   - 6 STATUS: RW1C
//   - 7 IRQEN:  RW
// - Reset values:
//   - All registers = 0.
//   - The synchronizer chain and the previous-input register are 0.
//   - PRDATA = 0, PSLVERR = 0, gpio_o = 0, gpio_oe = 0, irq_o = 0.
//   - PREADY = 1.
// - Write: commits on the rising edge at which PSEL & PENABLE & PWRITE & PSTRB[0] are all 1.
//   - PSTRB[0] = 0: no register changes and no error.
// - Read: PRDATA is combinational while PSEL & ~PWRITE, selected register; otherwise 0.
//   - An unmapped read returns 0.
// - PSLVERR: combinational, asserted only in the access phase (PSEL & PENABLE) when either holds:
//   - the address is unmapped;
//   - the transfer is a write to IN.
//   - The erroring access leaves state unchanged.
// - Input path: gpio_i passes through SYNC_DEPTH flops giving in_s; IN reads in_s.
//   - in_p holds in_s delayed by one cycle.
// - Per-pin trigger event, evaluated every cycle:
//   - level:        in_s == TPOL
//   - rising edge:  TPOL = 1 & in_s & ~in_p
//   - falling edge: TPOL = 0 & ~in_s & in_p
// - STATUS[i] rules:
//   - Set on an event; sets regardless of IRQEN.
//   - Cleared by writing 1 to bit i; writing 0 has no effect.
//   - Set and clear in the same cycle: set wins.
//   - A level event with the condition still true re-sets the bit on the next cycle.
// - irq_o <= |(STATUS & IRQEN), registered; 1 cycle after STATUS/IRQEN update.
// - Output drive:
//   - push-pull: gpio_o = OUT, gpio_oe = DIR
//   - open-drain: gpio_o = 0, gpio_oe = DIR & ~OUT
// - Latency from pin edge to STATUS: SYNC_DEPTH+1 cycles; to irq_o: SYNC_DEPTH+2 cycles.
// - Reset mid-transfer: all state returns to reset values immediately; the pending APB access is dropped.
// - Changing TTYPE/TPOL may itself create an event the next cycle (level mode); this is not suppressed.
// TESTING
// - Reset, then read all 8 regs -> all 0, PSLVERR=0.
//   Read 0x008 -> PRDATA=0, PSLVERR=1.
// - Write DIR=0xFF, OUT=0xA5, MODE=0x00 -> gpio_oe=0xFF, gpio_o=0xA5.
//   Then MODE=0xFF -> gpio_o=0x00, gpio_oe=0x5A.
// - gpio_i=0x3C held -> IN reads 0x3C after SYNC_DEPTH cycles.
//   Write IN -> PSLVERR=1, IN unchanged.
//   Write OUT with PSTRB=0 -> OUT unchanged, PSLVERR=0.
// - TTYPE=0x01, TPOL=0x01, IRQEN=0x01; gpio_i[0] 0->1 -> STATUS=0x01 after 3 cycles, irq_o=1 after 4.
//   Write STATUS=0x01 -> irq_o=0 one cycle later.
// - Level mode TTYPE=0, TPOL=0x00, gpio_i=0x00, IRQEN=0xFF -> STATUS=0xFF.
//   W1C 0xFF with inputs still low -> STATUS reads 0xFF again (set wins).
// - Assert PRESETn=0 during the access phase of a write to OUT=0x55 -> OUT=0, irq_o=0.
//   After release, no write has taken effect.

Source files
------------

// File: rtl/peripheral_gpio_apb4_if.sv
// APB4 bus bundle between the AHB3->APB4 bridge (master) and the GPIO slave.
// PRDATA/PREADY/PSLVERR are slave-driven; everything else comes from the master.
interface peripheral_gpio_apb4_if #(
    parameter int PADDR_SIZE = 10,
    parameter int PDATA_SIZE = 8
);
    logic                    PSEL;
    logic                    PENABLE;
    logic [PADDR_SIZE-1:0]   PADDR;
    logic                    PWRITE;
    logic [PDATA_SIZE/8-1:0] PSTRB;
    logic [PDATA_SIZE-1:0]   PWDATA;
    logic [PDATA_SIZE-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/peripheral_gpio_apb4.sv
// APB4 GPIO: per-pin direction, push-pull/open-drain drive, synchronized input, level/edge IRQ.
// Latency: zero-wait APB; pin edge to STATUS in SYNC_DEPTH+1 cycles, to irq_o in SYNC_DEPTH+2.
// Backpressure: none, PREADY is tied high; errored accesses complete with PSLVERR and no side effect.
module peripheral_gpio_apb4 #(
    parameter int PADDR_SIZE = 10,
    parameter int PDATA_SIZE = 8,
    parameter int SYNC_DEPTH = 2
) (
    input  logic                  PRESETn,
    input  logic                  PCLK,
    peripheral_gpio_apb4_if.slave apb,
    input  logic [PDATA_SIZE-1:0] gpio_i,
    output logic [PDATA_SIZE-1:0] gpio_o,
    output logic [PDATA_SIZE-1:0] gpio_oe,
    output logic                  irq_o
);
    localparam int SD = (SYNC_DEPTH < 2) ? 2 : SYNC_DEPTH;

    localparam logic [2:0] A_MODE   = 3'd0;
    localparam logic [2:0] A_DIR    = 3'd1;
    localparam logic [2:0] A_OUT    = 3'd2;
    localparam logic [2:0] A_IN     = 3'd3;
    localparam logic [2:0] A_TTYPE  = 3'd4;
    localparam logic [2:0] A_TPOL   = 3'd5;
    localparam logic [2:0] A_STATUS = 3'd6;
    localparam logic [2:0] A_IRQEN  = 3'd7;

    logic [SD-1:0][PDATA_SIZE-1:0] sync_q, sync_d;
    logic [PDATA_SIZE-1:0] in_p_q, in_p_d;
    logic [PDATA_SIZE-1:0] mode_q, mode_d;
    logic [PDATA_SIZE-1:0] dir_q, dir_d;
    logic [PDATA_SIZE-1:0] out_q, out_d;
    logic [PDATA_SIZE-1:0] ttype_q, ttype_d;
    logic [PDATA_SIZE-1:0] tpol_q, tpol_d;
    logic [PDATA_SIZE-1:0] status_q, status_d;
    logic [PDATA_SIZE-1:0] irqen_q, irqen_d;
    logic                  irq_q, irq_d;

    logic [PDATA_SIZE-1:0] in_s;
    logic [PDATA_SIZE-1:0] trig;
    logic [PDATA_SIZE-1:0] w1c_mask;
    logic [PDATA_SIZE-1:0] rd_dat;
    logic [2:0]            reg_sel;
    logic                  mapped;
    logic                  access;
    logic                  slv_err;
    logic                  wr_en;

    // ---------------------------------------------------------------
    // APB decode
    // ---------------------------------------------------------------
    assign reg_sel = apb.PADDR[2:0];
    assign mapped  = (apb.PADDR[PADDR_SIZE-1:3] == '0);
    assign access  = apb.PSEL & apb.PENABLE;
    assign slv_err = access & (~mapped | (apb.PWRITE & (reg_sel == A_IN)));
    assign wr_en   = access & apb.PWRITE & apb.PSTRB[0] & ~slv_err;

    // ---------------------------------------------------------------
    // Input synchronizer and trigger detection
    // ---------------------------------------------------------------
    assign in_s = sync_q[SD-1];

    always_comb begin
        sync_d = {sync_q[SD-2:0], gpio_i};
        in_p_d = in_s;
    end

    always_comb begin
        trig = '0;
        for (int i = 0; i < PDATA_SIZE; i++) begin
            if (ttype_q[i]) begin
                trig[i] = tpol_q[i] ? (in_s[i] & ~in_p_q[i]) : (~in_s[i] & in_p_q[i]);
            end else begin
                trig[i] = (in_s[i] == tpol_q[i]);
            end
        end
    end

    // ---------------------------------------------------------------
    // Register next-state
    // ---------------------------------------------------------------
    always_comb begin
        mode_d   = mode_q;
        dir_d    = dir_q;
        out_d    = out_q;
        ttype_d  = ttype_q;
        tpol_d   = tpol_q;
        irqen_d  = irqen_q;
        w1c_mask = '0;
        if (wr_en) begin
            case (reg_sel)
                A_MODE:   mode_d   = apb.PWDATA;
                A_DIR:    dir_d    = apb.PWDATA;
                A_OUT:    out_d    = apb.PWDATA;
                A_TTYPE:  ttype_d  = apb.PWDATA;
                A_TPOL:   tpol_d   = apb.PWDATA;
                A_STATUS: w1c_mask = apb.PWDATA;
                A_IRQEN:  irqen_d  = apb.PWDATA;
                default:  ;
            endcase
        end
        // A trigger in the same cycle as its clear keeps the bit set.
        status_d = (status_q & ~w1c_mask) | trig;
        irq_d    = |(status_q & irqen_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync_q   <= '0;
            in_p_q   <= '0;
            mode_q   <= '0;
            dir_q    <= '0;
            out_q    <= '0;
            ttype_q  <= '0;
            tpol_q   <= '0;
            status_q <= '0;
            irqen_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            in_p_q   <= in_p_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            out_q    <= out_d;
            ttype_q  <= ttype_d;
            tpol_q   <= tpol_d;
            status_q <= status_d;
            irqen_q  <= irqen_d;
            irq_q    <= irq_d;
        end
    end

    // ---------------------------------------------------------------
    // Read mux and bus response
    // ---------------------------------------------------------------
    always_comb begin
        rd_dat = '0;
        if (apb.PSEL & ~apb.PWRITE & mapped) begin
            case (reg_sel)
                A_MODE:   rd_dat = mode_q;
                A_DIR:    rd_dat = dir_q;
                A_OUT:    rd_dat = out_q;
                A_IN:     rd_dat = in_s;
                A_TTYPE:  rd_dat = ttype_q;
                A_TPOL:   rd_dat = tpol_q;
                A_STATUS: rd_dat = status_q;
                A_IRQEN:  rd_dat = irqen_q;
                default:  rd_dat = '0;
            endcase
        end
    end

    assign apb.PRDATA  = rd_dat;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = slv_err;

    // Open-drain pins only ever pull low: drive enabled exactly when OUT is 0.
    assign gpio_o  = out_q & ~mode_q;
    assign gpio_oe = dir_q & ~(mode_q & out_q);
    assign irq_o   = irq_q;
endmodule

// File: tb/tb_peripheral_gpio_apb4.sv
// Bench for peripheral_gpio_apb4: directed scenarios then random register/pin traffic,
// compared against a pin-history reference model.
module tb_peripheral_gpio_apb4;
    localparam int SD = 2;

    logic       PCLK;
    logic       PRESETn;
    logic [7:0] gpio_i;
    logic [7:0] gpio_o;
    logic [7:0] gpio_oe;
    logic       irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    peripheral_gpio_apb4_if #(.PADDR_SIZE(10), .PDATA_SIZE(8)) apb ();

    peripheral_gpio_apb4 #(.PADDR_SIZE(10), .PDATA_SIZE(8), .SYNC_DEPTH(SD)) dut (
        .PRESETn (PRESETn),
        .PCLK    (PCLK),
        .apb     (apb),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq_o   (irq_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Reference model: IN is simply the pin value seen SD clocks ago.
    logic [7:0] m_reg [8];
    logic [7:0] hist  [64];
    logic [7:0] m_in;
    logic [7:0] m_inp;
    logic       m_irq;
    int         m_cyc;

    function automatic logic [7:0] trig_of(input logic [7:0] tt, input logic [7:0] tp,
                                           input logic [7:0] cur, input logic [7:0] prev);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (tt[i]) r[i] = tp[i] ? (cur[i] && !prev[i]) : (!cur[i] && prev[i]);
            else       r[i] = (cur[i] == tp[i]);
        end
        return r;
    endfunction

    function automatic logic addr_err(input logic [9:0] a, input logic wr);
        return (a[9:3] != 7'd0) || (wr && a[2:0] == 3'd3);
    endfunction

    function automatic logic model_commit();
        return apb.PSEL && apb.PENABLE && apb.PWRITE && apb.PSTRB[0] && !addr_err(apb.PADDR, 1'b1);
    endfunction

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < 8; i++) m_reg[i] <= 8'h00;
            m_in  <= 8'h00;
            m_inp <= 8'h00;
            m_irq <= 1'b0;
            m_cyc <= 0;
        end else begin
            hist[m_cyc % 64] <= gpio_i;
            m_in  <= (m_cyc + 1 >= SD) ? hist[(m_cyc + 1 - SD) % 64] : 8'h00;
            m_inp <= m_in;
            m_irq <= |(m_reg[6] & m_reg[7]);
            if (model_commit() && apb.PADDR[2:0] != 3'd6)
                m_reg[apb.PADDR[2:0]] <= apb.PWDATA;
            m_reg[6] <= (m_reg[6] & ~((model_commit() && apb.PADDR[2:0] == 3'd6) ? apb.PWDATA : 8'h00))
                        | trig_of(m_reg[4], m_reg[5], m_in, m_inp);
            m_cyc <= m_cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Combinational read with no clock edge in between: nothing can commit.
    task automatic peek(input logic [9:0] a, output logic [7:0] d, output logic e);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b1;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = a;
        #1;
        d = apb.PRDATA;
        e = apb.PSLVERR;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [9:0] a, input logic [7:0] d, input logic s, input string tag);
        @(negedge PCLK);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = a;
        apb.PWDATA  = d;
        apb.PSTRB   = s;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        #1;
        check({tag, "_pslverr"}, 32'(apb.PSLVERR), 32'(addr_err(a, 1'b1)));
        @(negedge PCLK);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
    endtask

    task automatic check_all(input string ctx);
        logic [7:0] d;
        logic       e;
        logic [7:0] eo, eoe;
        for (int a = 0; a < 8; a++) begin
            peek(10'(a), d, e);
            check($sformatf("%s_reg%0d", ctx, a), 32'(d), 32'((a == 3) ? m_in : m_reg[a]));
        end
        for (int i = 0; i < 8; i++) begin
            eo[i]  = m_reg[0][i] ? 1'b0 : m_reg[2][i];
            eoe[i] = m_reg[0][i] ? (m_reg[1][i] && !m_reg[2][i]) : m_reg[1][i];
        end
        check({ctx, "_gpio_o"}, 32'(gpio_o), 32'(eo));
        check({ctx, "_gpio_oe"}, 32'(gpio_oe), 32'(eoe));
        check({ctx, "_irq"}, 32'(irq_o), 32'(m_irq));
    endtask

    initial begin
        logic [7:0] d;
        logic       e;
        logic [9:0] ra;

        PRESETn     = 1'b0;
        gpio_i      = 8'h00;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PSTRB   = 1'b1;
        apb.PWDATA  = '0;

        // Reset values, observed while reset is held.
        repeat (2) @(negedge PCLK);
        for (int a = 0; a < 8; a++) begin
            peek(10'(a), d, e);
            check($sformatf("rst_reg%0d", a), 32'(d), 32'h0);
            check($sformatf("rst_err%0d", a), 32'(e), 32'h0);
        end
        check("rst_gpio_o", 32'(gpio_o), 32'h0);
        check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_pready", 32'(apb.PREADY), 32'h1);

        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (3) @(negedge PCLK);
        peek(10'h008, d, e);
        check("unmapped_rdata", 32'(d), 32'h0);
        check("unmapped_err", 32'(e), 32'h1);
        check_all("post_rst");

        // Push-pull then open-drain drive.
        apb_write(10'h001, 8'hFF, 1'b1, "wr_dir");
        apb_write(10'h002, 8'hA5, 1'b1, "wr_out");
        apb_write(10'h000, 8'h00, 1'b1, "wr_mode_pp");
        check("pp_gpio_oe", 32'(gpio_oe), 32'hFF);
        check("pp_gpio_o", 32'(gpio_o), 32'hA5);
        apb_write(10'h000, 8'hFF, 1'b1, "wr_mode_od");
        check("od_gpio_o", 32'(gpio_o), 32'h00);
        check("od_gpio_oe", 32'(gpio_oe), 32'h5A);

        // Input readback, write to IN, strobe-less write.
        @(negedge PCLK);
        gpio_i = 8'h3C;
        repeat (SD) @(negedge PCLK);
        peek(10'h003, d, e);
        check("in_sync", 32'(d), 32'h3C);
        apb_write(10'h003, 8'h00, 1'b1, "wr_in");
        peek(10'h003, d, e);
        check("in_after_wr", 32'(d), 32'h3C);
        apb_write(10'h002, 8'h00, 1'b0, "wr_nostrb");
        peek(10'h002, d, e);
        check("out_nostrb", 32'(d), 32'hA5);
        check_all("io");

        // Rising-edge interrupt latency on pin 0.
        gpio_i = 8'h00;
        apb_write(10'h004, 8'hFF, 1'b1, "wr_ttype");
        apb_write(10'h005, 8'h01, 1'b1, "wr_tpol");
        repeat (4) @(negedge PCLK);
        apb_write(10'h006, 8'hFF, 1'b1, "clr_status");
        apb_write(10'h007, 8'h01, 1'b1, "wr_irqen");
        peek(10'h006, d, e);
        check("edge_idle_status", 32'(d), 32'h00);
        @(negedge PCLK);
        gpio_i = 8'h01;
        repeat (2) @(negedge PCLK);
        peek(10'h006, d, e);
        check("edge_status_2cyc", 32'(d), 32'h00);
        @(negedge PCLK);
        peek(10'h006, d, e);
        check("edge_status_3cyc", 32'(d), 32'h01);
        check("edge_irq_3cyc", 32'(irq_o), 32'h0);
        @(negedge PCLK);
        check("edge_irq_4cyc", 32'(irq_o), 32'h1);
        apb_write(10'h006, 8'h01, 1'b1, "w1c_edge");
        check("w1c_irq_same", 32'(irq_o), 32'h1);
        @(negedge PCLK);
        check("w1c_irq_next", 32'(irq_o), 32'h0);
        check_all("edge");

        // Level-low triggers win over W1C while the pins stay low.
        gpio_i = 8'h00;
        apb_write(10'h004, 8'h00, 1'b1, "lvl_ttype");
        apb_write(10'h005, 8'h00, 1'b1, "lvl_tpol");
        apb_write(10'h007, 8'hFF, 1'b1, "lvl_irqen");
        repeat (3) @(negedge PCLK);
        peek(10'h006, d, e);
        check("lvl_status", 32'(d), 32'hFF);
        check("lvl_irq", 32'(irq_o), 32'h1);
        apb_write(10'h006, 8'hFF, 1'b1, "lvl_w1c");
        peek(10'h006, d, e);
        check("lvl_set_wins", 32'(d), 32'hFF);
        check_all("lvl");

        // Random register and pin traffic.
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge PCLK);
                gpio_i = 8'($urandom);
            end else begin
                if ($urandom_range(0, 9) == 0) ra = {7'($urandom_range(1, 127)), 3'($urandom_range(0, 7))};
                else                            ra = {7'd0, 3'($urandom_range(0, 7))};
                apb_write(ra, 8'($urandom), ($urandom_range(0, 4) != 0), $sformatf("rnd%0d", it));
            end
            check_all($sformatf("rnd%0d", it));
        end

        // Reset asserted during the access phase of a write.
        apb_write(10'h007, 8'hFF, 1'b1, "pre_rst_irqen");
        repeat (2) @(negedge PCLK);
        @(negedge PCLK);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = 10'h002;
        apb.PWDATA  = 8'h55;
        apb.PSTRB   = 1'b1;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        #1;
        PRESETn = 1'b0;
        #1;
        check("midrst_irq", 32'(irq_o), 32'h0);
        check("midrst_gpio_o", 32'(gpio_o), 32'h0);
        @(negedge PCLK);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        peek(10'h002, d, e);
        check("midrst_out", 32'(d), 32'h00);
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);
        peek(10'h002, d, e);
        check("postrst_out", 32'(d), 32'h00);
        check_all("postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
